// File: rtl/coin_input_conditioner.sv
// Coin slot front end: synchronizes and debounces four raw coin switches.
// Each clean insertion becomes one value, queued in a FWFT FIFO with a valid/ready handshake.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int VAL_DOLLAR      = 20,
    parameter int VAL_FIFTY       = 10,
    parameter int VAL_TEN         = 2,
    parameter int VAL_FIVE        = 1,
    localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Enable,
    input  logic             OneDollar,
    input  logic             FiftyCents,
    input  logic             TenCents,
    input  logic             FiveCents,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [4:0]       coin_value,
    output logic             multi_err,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [3:0]       raw_in;
    logic [3:0]       sync_s1;
    logic [3:0]       sync_s2;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       rise;

    logic             push;
    logic             multi_hit;
    logic [4:0]       push_value;

    logic [4:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             wr_en;

    // Channel order: bit 3 dollar, 2 fifty, 1 ten, 0 five
    assign raw_in = {OneDollar, FiftyCents, TenCents, FiveCents};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= raw_in;
            sync_s2 <= sync_s1;
        end
    end

    // Stable state only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync_s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise      = stable & ~stable_d;
    assign push      = Enable & $onehot(rise);
    assign multi_hit = Enable & ($countones(rise) > 1);

    always_comb begin
        push_value = '0;
        if (rise[3]) begin
            push_value = 5'(VAL_DOLLAR);
        end else if (rise[2]) begin
            push_value = 5'(VAL_FIFTY);
        end else if (rise[1]) begin
            push_value = 5'(VAL_TEN);
        end else if (rise[0]) begin
            push_value = 5'(VAL_FIVE);
        end
    end

    assign coin_valid = (fifo_level != '0);
    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop        = coin_valid & coin_ready;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands
    assign wr_en      = push & (~full | pop);
    assign coin_value = coin_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            multi_err  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            multi_err <= multi_hit;
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
            if (wr_en) begin
                mem[wr_ptr] <= push_value;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: directed scenarios plus random coin traffic.
// A queue-based model of debounce, merge and FIFO is compared against the DUT every cycle.
module tb_coin_input_conditioner;

    localparam int D     = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       one_dollar = 1'b0;
    logic       fifty = 1'b0;
    logic       ten = 1'b0;
    logic       five = 1'b0;
    logic       coin_ready = 1'b0;
    logic       coin_valid;
    logic [4:0] coin_value;
    logic       multi_err;
    logic       overflow;
    logic [2:0] fifo_level;

    int nChecks = 0;
    int nFails = 0;
    int multiErrSeen = 0;
    int cycleCount = 0;

    logic [3:0] hq[$];
    int         quiet[4] = '{default: 0};
    logic [3:0] mStable = '0;
    logic [3:0] pendingRise = '0;
    int         q[$];
    bit         mOverflow = 1'b0;
    bit         mMulti = 1'b0;
    int         valueOf[4] = '{1, 2, 10, 20};

    always #5 clk = ~clk;

    coin_input_conditioner dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .Enable     (enable),
        .OneDollar  (one_dollar),
        .FiftyCents (fifty),
        .TenCents   (ten),
        .FiveCents  (five),
        .coin_ready (coin_ready),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .multi_err  (multi_err),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit rawAgo(input int m, input int ch);
        int idx;
        idx = hq.size() - 1 - m;
        if (idx < 0) return 1'b0;
        return hq[idx][ch];
    endfunction

    // Raw samples taken m edges ago; pre-reset history counts as low
    task automatic modelStep();
        logic [3:0] raw;
        logic [3:0] flips;
        bit         allDiff;
        int         nRise;
        int         pushVal;
        bit         popNow;
        raw   = {one_dollar, fifty, ten, five};
        flips = '0;
        hq.push_back(raw);
        if (hq.size() > D + 2) void'(hq.pop_front());
        for (int ch = 0; ch < 4; ch++) begin
            quiet[ch]++;
            if (quiet[ch] >= D) begin
                allDiff = 1'b1;
                for (int m = 2; m <= D + 1; m++) begin
                    if (rawAgo(m, ch) == mStable[ch]) allDiff = 1'b0;
                end
                flips[ch] = allDiff;
            end
        end
        nRise   = $countones(pendingRise);
        pushVal = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (pendingRise[ch]) pushVal = valueOf[ch];
        end
        popNow = (q.size() > 0) && coin_ready;
        mMulti = enable && (nRise >= 2);
        if (popNow) void'(q.pop_front());
        if (enable && nRise == 1) begin
            if (q.size() < DEPTH) q.push_back(pushVal);
            else mOverflow = 1'b1;
        end
        pendingRise = flips & ~mStable;
        for (int ch = 0; ch < 4; ch++) begin
            if (flips[ch]) begin
                mStable[ch] = ~mStable[ch];
                quiet[ch]   = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            hq.delete();
            q.delete();
            quiet       = '{default: 0};
            mStable     = '0;
            pendingRise = '0;
            mOverflow   = 1'b0;
            mMulti      = 1'b0;
        end else begin
            modelStep();
        end
        cycleCount++;
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        if (multi_err) multiErrSeen++;
        if (cycleCount > 1) begin
            checkOutput("model_valid", int'(coin_valid), int'(q.size() > 0));
            checkOutput("model_value", int'(coin_value), (q.size() > 0) ? q[0] : 0);
            checkOutput("model_level", int'(fifo_level), q.size());
            checkOutput("model_overflow", int'(overflow), int'(mOverflow));
            checkOutput("model_multi_err", int'(multi_err), int'(mMulti));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic d, input logic f, input logic t, input logic v);
        one_dollar = d;
        fifty      = f;
        ten        = t;
        five       = v;
    endtask

    task automatic insertCoin(input int ch);
        logic [3:0] b;
        b = 4'b0001 << ch;
        applyStimulus(b[3], b[2], b[1], b[0]);
        tick(22);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(22);
    endtask

    // Reset edges kept clear of both clock edges; inputs go low while in reset
    task automatic pulseReset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drainExpect(input int n, input int vals[4]);
        coin_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checkOutput("drain_valid", int'(coin_valid), 1);
            checkOutput("drain_value", int'(coin_value), vals[i]);
            tick(1);
        end
        coin_ready = 1'b0;
        checkOutput("drain_empty_valid", int'(coin_valid), 0);
        checkOutput("drain_empty_level", int'(fifo_level), 0);
    endtask

    initial begin
        #1_000_000;
        nFails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mBase;
        int hold[4];
        logic [3:0] lvl;
        bit stall;

        tick(3);
        checkOutput("in_reset_valid", int'(coin_valid), 0);
        checkOutput("in_reset_level", int'(fifo_level), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_valid", int'(coin_valid), 0);
        checkOutput("reset_value", int'(coin_value), 0);
        checkOutput("reset_level", int'(fifo_level), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        checkOutput("reset_multi_err", int'(multi_err), 0);

        $display("[TB] bouncing FiftyCents");
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            tick(2);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            tick(2);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick(18);
        checkOutput("fifty_valid_edge18", int'(coin_valid), 0);
        tick(1);
        checkOutput("fifty_valid_edge19", int'(coin_valid), 1);
        checkOutput("fifty_value", int'(coin_value), 10);
        checkOutput("fifty_level", int'(fifo_level), 1);
        tick(10);
        checkOutput("fifty_held_level", int'(fifo_level), 1);
        coin_ready = 1'b1;
        tick(1);
        coin_ready = 1'b0;
        checkOutput("fifty_popped_valid", int'(coin_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(22);

        $display("[TB] short TenCents pulse");
        mBase = multiErrSeen;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick(10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(30);
        checkOutput("glitch_valid", int'(coin_valid), 0);
        checkOutput("glitch_multi_count", multiErrSeen - mBase, 0);

        $display("[TB] simultaneous OneDollar and FiveCents");
        mBase = multiErrSeen;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick(25);
        checkOutput("dual_multi_count", multiErrSeen - mBase, 1);
        checkOutput("dual_level", int'(fifo_level), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(22);

        $display("[TB] overflow with five FiveCents coins");
        for (int i = 0; i < 5; i++) insertCoin(0);
        checkOutput("ovf_level", int'(fifo_level), 4);
        checkOutput("ovf_flag", int'(overflow), 1);
        drainExpect(4, '{1, 1, 1, 1});
        checkOutput("ovf_sticky", int'(overflow), 1);
        pulseReset();
        checkOutput("ovf_cleared", int'(overflow), 0);

        $display("[TB] push and pop on a full FIFO");
        for (int i = 0; i < 4; i++) insertCoin(0);
        checkOutput("full_level", int'(fifo_level), 4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick(18);
        coin_ready = 1'b1;
        tick(1);
        coin_ready = 1'b0;
        checkOutput("pushpop_level", int'(fifo_level), 4);
        checkOutput("pushpop_overflow", int'(overflow), 0);
        drainExpect(4, '{1, 1, 1, 2});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(22);

        $display("[TB] Enable low during OneDollar");
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(25);
        checkOutput("disabled_level", int'(fifo_level), 0);
        checkOutput("disabled_valid", int'(coin_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(22);
        enable = 1'b1;

        $display("[TB] reset during FiftyCents debounce");
        mBase = multiErrSeen;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick(10);
        pulseReset();
        tick(25);
        checkOutput("midreset_valid", int'(coin_valid), 0);
        checkOutput("midreset_value", int'(coin_value), 0);
        checkOutput("midreset_level", int'(fifo_level), 0);
        checkOutput("midreset_overflow", int'(overflow), 0);
        checkOutput("midreset_multi_count", multiErrSeen - mBase, 0);

        $display("[TB] random coin traffic");
        lvl = '0;
        for (int ch = 0; ch < 4; ch++) hold[ch] = $urandom_range(0, 60);
        for (int c = 0; c < 3000; c++) begin
            stall      = ((c / 400) % 3) == 1;
            coin_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            enable     = ($urandom_range(0, 19) != 0);
            for (int ch = 0; ch < 4; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    if (lvl[ch]) begin
                        hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12)
                                                               : $urandom_range(18, 60);
                    end else begin
                        hold[ch] = $urandom_range(10, 120);
                    end
                end else begin
                    hold[ch]--;
                end
            end
            applyStimulus(lvl[3], lvl[2], lvl[1], lvl[0]);
            tick(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        enable     = 1'b1;
        coin_ready = 1'b1;
        tick(60);
        checkOutput("final_valid", int'(coin_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front end of the vending machine. Takes the four raw, bouncing coin-slot switches and turns each clean coin insertion into exactly one coin event.
- Events are buffered in a small FIFO and presented to the vending FSM through a valid/ready handshake. The FSM therefore sees single-cycle, non-repeating coin values and never misses a coin while it is in RELEASE_ITEM.
- Coin values are in 5-cent units, matching the FSM accumulator (item price 25 = $1.25).

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from its stable state before the stable state flips (>=2).
- FIFO_DEPTH, 4: coin-event buffer entries (power of 2, >=2).
- VAL_DOLLAR, 20: value pushed for OneDollar.
- VAL_FIFTY, 10: value pushed for FiftyCents.
- VAL_TEN, 2: value pushed for TenCents.
- VAL_FIVE, 1: value pushed for FiveCents.
- LVL_W, $clog2(FIFO_DEPTH+1): fifo_level width (derived; 3 at default).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- Enable  input  1  synchronous; when 0, debounced rising edges are discarded (not queued, no error).
- OneDollar  input  1  raw slot switch, asynchronous to CLK.
- FiftyCents  input  1  raw slot switch, asynchronous to CLK.
- TenCents  input  1  raw slot switch, asynchronous to CLK.
- FiveCents  input  1  raw slot switch, asynchronous to CLK.
- coin_ready  input  1  consumer accepts head entry this cycle.
- coin_valid  output  1  FIFO non-empty.
- coin_value  output  5  head entry value, 5-cent units; 0 when coin_valid=0.
- multi_err  output  1  one-cycle pulse: simultaneous coin edges rejected.
- overflow  output  1  sticky; a coin event was dropped because the FIFO was full.
- fifo_level  output  LVL_W  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (RST_N=0, async): all outputs and state clear to 0.
  - Synchronizers, debounce counters, stable states, edge-history registers, FIFO pointers and overflow all go to 0.
  - Inputs that are high at reset release are treated as a new rising edge once debounced (the stable state starts at 0).
- Sync: 2-flop synchronizer per channel (s1 to s2).
- Debounce, per channel:
  - If s2 == stable, counter clears to 0.
  - Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1 and s2 still differs, stable <= s2 and counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles leaves stable unchanged.
- Edge detect: rise[i] = stable[i] & ~stable_d[i]. Falling edges are ignored.
- Merge, evaluated each cycle:
  - Enable=0: all rises are dropped.
  - Exactly one rise: push the corresponding VAL_* value.
  - Two or more rises in the same cycle: push nothing, pulse multi_err for 1 cycle.
- Latency: raw input rising, held stable, appears as coin_valid=1 after DEBOUNCE_CYCLES+3 rising edges, counted from the first edge that samples it high (19 at default), when the FIFO is empty.
- FIFO:
  - pop = coin_valid & coin_ready.
  - A push while not full is stored at the tail.
  - Push while full:
    - Push and pop in the same cycle: both happen, level unchanged, no overflow.
    - Push without pop: entry dropped, overflow <= 1 and held until reset.
  - Pop while empty: no effect; coin_valid=0 means coin_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is exact, registered, and updates on the same edge as the push/pop.
  - coin_value is the head entry directly (first-word-fall-through), so it is valid in the same cycle coin_valid rises.
- Reset mid-debounce or with FIFO non-empty: everything is lost, no partial event is emitted after release.
- Holding an input high indefinitely produces exactly one event. The next event on that channel requires a debounced low and then a debounced high.

Test Plan:
- FiftyCents raw 0→1 at edge 0 with 3 bounces of 2 cycles each, then held high → exactly one entry, coin_value=10, coin_valid first high at edge 19 after the last bounce settles; fifo_level=1.
- TenCents 10-cycle pulse (< DEBOUNCE_CYCLES) → no entry, coin_valid stays 0, multi_err 0.
- OneDollar and FiveCents driven high on the same edge, both held → multi_err pulses exactly 1 cycle, fifo_level stays 0.
- coin_ready=0, insert 5 clean FiveCents coins → fifo_level=4 and overflow=1 after the 5th. Then coin_ready=1 → pops return 1,1,1,1 and coin_valid drops to 0.
- FIFO full with coin_ready=1 and a new TenCents event on the same cycle → level stays 4, overflow stays 0, tail holds value 2.
- Enable=0 during a clean OneDollar insertion → no entry. Separately, assert RST_N=0 mid-debounce of a FiftyCents coin, release it with the input low → all outputs 0, no event.
